// File: rtl/wram_arbiter_if.sv
// wram_arbiter_if
//   Bundles the client-side signals of the work-RAM arbiter: the CPU bus,
//   the OAM-DMA control pins and the OAM write port.
//   master : CPU / DMA-control side (drives requests, receives responses)
//   slave  : the arbiter itself
//
// Handshake semantics: cpu_req is held high with stable cpu_we/addr/wdata
// until a cycle in which cpu_gnt=1; that cycle is the access. A granted
// read returns cpu_rvalid=1 with cpu_rdata exactly one cycle later, with no
// backpressure. dma_start is a single-cycle pulse honoured only while
// dma_busy=0. oam_wr_valid is a one-cycle strobe with no ready; the OAM
// always accepts.
interface wram_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  dma_start;
  logic [ADDR_WIDTH-1:0] dma_src_base;
  logic                  dma_busy;
  logic                  dma_done;
  logic                  oam_wr_valid;
  logic [7:0]            oam_wr_addr;
  logic [DATA_WIDTH-1:0] oam_wr_data;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_start, dma_src_base,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dma_busy, dma_done,
           oam_wr_valid, oam_wr_addr, oam_wr_data
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_start, dma_src_base,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dma_busy, dma_done,
           oam_wr_valid, oam_wr_addr, oam_wr_data
  );
endinterface

// File: rtl/wram_arbiter.sv
// wram_arbiter
//   Owns the single port of the work-RAM macro (registered read, one-cycle
//   latency) and shares it between the CPU bus and an OAM-DMA sequencer
//   that copies DMA_BURST bytes from work RAM to the OAM write port.
//   The CPU wins the slot, except that after STARVE_LIMIT consecutive CPU
//   grants with a DMA read pending the DMA takes the slot.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : CPU bus, DMA control and OAM write port
//   ram_*           : pins of the RAM macro (write = ce1 & ce2)
//   dbg_state       : current sequencer state (0 IDLE, 1 RUN, 2 DRAIN)
module wram_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 8,
  parameter int DMA_BURST    = 160,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wram_arbiter_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_ce1,
  output logic                  ram_ce2,
  output logic                  ram_oe,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [1:0]            dbg_state
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]    IDX_LAST   = 8'(DMA_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [7:0]            idx_q, idx_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  ram_oe_q, ram_oe_d;
  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic                  oam_valid_q, oam_valid_d;
  logic [7:0]            oam_idx_q, oam_idx_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;

  logic                  dma_pending;
  logic                  cpu_win;
  logic                  cpu_slot;
  logic                  dma_slot;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic                  dma_done_c;

  // Slot ownership. Grants are masked while rst_n is low so every output
  // drops to zero the moment reset is asserted, not at the next edge.
  always_comb begin
    dma_pending = (state_q == S_RUN);
    cpu_win     = bus.cpu_req && !(dma_pending && (starve_q == STARVE_MAX));
    cpu_slot    = rst_n && cpu_win;
    dma_slot    = rst_n && dma_pending && !cpu_win;
    dma_addr    = base_q + ADDR_WIDTH'(idx_q);   // wraps modulo 2^ADDR_WIDTH
  end

  // Starvation counter: counts CPU grants that pushed a pending DMA read back.
  always_comb begin
    starve_d = starve_q;
    if (!dma_pending || dma_slot) begin
      starve_d = '0;
    end else if (cpu_slot && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Sequencer next state.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    dma_done_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.dma_start) begin
          base_d  = bus.dma_src_base;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (dma_slot) begin
          idx_d = idx_q + 8'd1;
          if (idx_q == IDX_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last byte's read data is on ram_rdata in this cycle.
        dma_done_c = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM port drive and read-return bookkeeping.
  always_comb begin
    ram_ce1  = cpu_slot || dma_slot;
    ram_ce2  = cpu_slot && bus.cpu_we;
    ram_wdata = ram_ce2 ? bus.cpu_wdata : '0;
    if (cpu_slot)      ram_addr = bus.cpu_addr;
    else if (dma_slot) ram_addr = dma_addr;
    else               ram_addr = ram_addr_q;  // idle slot keeps the last address
    ram_addr_d   = ram_addr;
    cpu_rvalid_d = cpu_slot && !bus.cpu_we;
    oam_valid_d  = dma_slot;
    oam_idx_d    = dma_slot ? idx_q : oam_idx_q;
    ram_oe_d     = cpu_rvalid_d || dma_slot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      starve_q     <= '0;
      ram_oe_q     <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      oam_valid_q  <= 1'b0;
      oam_idx_q    <= '0;
      ram_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      starve_q     <= starve_d;
      ram_oe_q     <= ram_oe_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      oam_valid_q  <= oam_valid_d;
      oam_idx_q    <= oam_idx_d;
      ram_addr_q   <= ram_addr_d;
    end
  end

  assign ram_oe           = ram_oe_q;
  assign bus.cpu_gnt      = cpu_slot;
  assign bus.cpu_rvalid   = cpu_rvalid_q;
  assign bus.cpu_rdata    = cpu_rvalid_q ? ram_rdata : '0;
  assign bus.dma_busy     = (state_q != S_IDLE);
  assign bus.dma_done     = dma_done_c;
  assign bus.oam_wr_valid = oam_valid_q;
  assign bus.oam_wr_addr  = oam_idx_q;
  assign bus.oam_wr_data  = oam_valid_q ? ram_rdata : '0;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_wram_arbiter.sv
module tb_wram_arbiter;

  localparam int BURST  = 160;
  localparam int STARVE = 4;

  logic        clk;
  logic        rst_n;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_ce1, ram_ce2, ram_oe;
  logic [7:0]  ram_rdata;
  logic [1:0]  dbg_state;

  wram_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) bus ();

  wram_arbiter #(
    .ADDR_WIDTH(13), .DATA_WIDTH(8), .DMA_BURST(BURST), .STARVE_LIMIT(STARVE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ce1(ram_ce1),
    .ram_ce2(ram_ce2), .ram_oe(ram_oe), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM macro model ----------------
  logic [7:0] mem [0:8191];
  logic [7:0] rd_q;
  logic       preload_req;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'(i);
    end else if (ram_ce1 && ram_ce2) begin
      mem[ram_addr] <= ram_wdata;
    end else if (ram_ce1) begin
      rd_q <= mem[ram_addr];
    end
  end
  assign ram_rdata = ram_oe ? rd_q : 8'hFF;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  cpu_exp_q[$];
  logic [15:0] oam_exp_q[$];   // {oam index, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cpu_rvalid) begin
        if (cpu_exp_q.size() == 0) check("cpu_rvalid_unexpected", 32'd1, 32'd0);
        else check("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, cpu_exp_q.pop_front()});
      end
      if (bus.oam_wr_valid) begin
        if (oam_exp_q.size() == 0) check("oam_valid_unexpected", 32'd1, 32'd0);
        else check("oam_write", {16'd0, bus.oam_wr_addr, bus.oam_wr_data},
                   {16'd0, oam_exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    check({tag, "_ctl"},
          {20'd0, bus.cpu_gnt, bus.cpu_rvalid, bus.dma_busy, bus.dma_done,
           bus.oam_wr_valid, ram_ce1, ram_ce2, ram_oe, dbg_state, 2'b00}, 32'd0);
    check({tag, "_data"},
          {8'd0, bus.cpu_rdata, bus.oam_wr_addr, bus.oam_wr_data}, 32'd0);
    check({tag, "_ram"}, {11'd0, ram_addr, ram_wdata}, 32'd0);
  endtask

  task automatic preload();
    @(posedge clk); #1;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [12:0] addr,
                            input logic [7:0] wdata, input logic [7:0] exp);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    @(negedge clk);
    check("cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
    check("cpu_ram_addr", {19'd0, ram_addr}, {19'd0, addr});
    check("cpu_ce2", {30'd0, ram_ce1, ram_ce2}, {30'd0, 1'b1, we});
    if (!we) cpu_exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    check("cpu_rvalid_latency", {31'd0, bus.cpu_rvalid}, {31'd0, !we});
    check("idle_addr_hold", {18'd0, ram_ce1, ram_addr}, {18'd0, 1'b0, addr});
  endtask

  task automatic dma_run(input logic [12:0] base, input bit cpu_hold,
                         input int repulse_at, input int reset_at);
    int cyc, done_cnt, done_cyc, dma_k, run, pattern_bad, exp_cyc;
    bit stop, aborted, pulse;
    logic [12:0] a;
    cyc = 0; done_cnt = 0; done_cyc = 0; dma_k = 0; run = 0; pattern_bad = 0;
    stop = 1'b0; aborted = 1'b0;
    exp_cyc = 2 + BURST * (cpu_hold ? (STARVE + 1) : 1);
    @(posedge clk); #1;
    bus.dma_start = 1'b1; bus.dma_src_base = base;
    bus.cpu_req = cpu_hold; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0005;
    for (int i = 0; i < BURST; i++) begin
      a = base + 13'(i);
      oam_exp_q.push_back({8'(i), a[7:0]});
    end
    while (!stop) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && cpu_hold)
        check("start_with_cpu_req", {30'd0, bus.cpu_gnt, bus.dma_busy}, {30'd0, 2'b10});
      if (bus.cpu_gnt) begin
        cpu_exp_q.push_back(8'h05);
        if (bus.dma_busy) run++;
      end
      if (ram_ce1 && !bus.cpu_gnt) begin
        a = base + 13'(dma_k);
        check("dma_src_addr", {19'd0, ram_addr}, {19'd0, a});
        if (cpu_hold && run != STARVE) pattern_bad++;
        run = 0;
        dma_k++;
      end
      if (bus.dma_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) begin
        check("busy_low_after_done", {31'd0, bus.dma_busy}, 32'd0);
        stop = 1'b1;
      end
      if (reset_at >= 0 && bus.oam_wr_valid && bus.oam_wr_addr == 8'(reset_at)) begin
        aborted = 1'b1;
        stop = 1'b1;
      end
      if (cyc >= 2000) begin
        check("dma_timeout", 32'd1, 32'd0);
        stop = 1'b1;
      end
      pulse = (repulse_at >= 0) && bus.oam_wr_valid && (bus.oam_wr_addr == 8'(repulse_at));
      if (!stop) begin
        @(posedge clk); #1;
        bus.dma_start = pulse;
        if (pulse) bus.dma_src_base = 13'h0000;
      end
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.dma_start = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check_zero("abort");
      oam_exp_q.delete();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (bus.dma_done || bus.oam_wr_valid) done_cnt++;
      end
      check("abort_no_done", done_cnt, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      check("done_count", done_cnt, 32'd1);
      check("done_cycle", done_cyc, exp_cyc);
      check("dma_grants", dma_k, BURST);
      if (cpu_hold) check("starve_pattern", pattern_bad, 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; preload_req = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_start = 1'b0; bus.dma_src_base = '0;
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    cpu_access(1'b1, 13'h0123, 8'hA5, 8'h00);
    cpu_access(1'b0, 13'h0123, 8'h00, 8'hA5);

    preload();
    dma_run(13'h0100, 1'b0, -1, -1);
    dma_run(13'h0100, 1'b1, -1, -1);
    dma_run(13'h1FF0, 1'b0, -1, -1);
    dma_run(13'h0100, 1'b0, 50, -1);
    dma_run(13'h0200, 1'b0, -1, 80);
    dma_run(13'h0300, 1'b0, -1, -1);

    repeat (4) @(negedge clk);
    check("cpu_queue_empty", cpu_exp_q.size(), 32'd0);
    check("oam_queue_empty", oam_exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wram_arbiter.md
Name: wram_arbiter

Overview:
- Owns the single port of the 8 KiB work-RAM macro (13-bit address, 8-bit data, registered read, one-cycle latency).
- Shares that port between the CPU bus and an internal OAM-DMA sequencer.
- The DMA sequencer streams DMA_BURST bytes from work RAM to the OAM write port.
- The CPU has priority, but a starvation limit guarantees DMA forward progress.

Parameters:
ADDR_WIDTH, 13, work-RAM address width
DATA_WIDTH, 8, work-RAM data width
DMA_BURST, 160, bytes per DMA transfer (1..256)
STARVE_LIMIT, 4, max consecutive CPU grants while a DMA read is pending

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, held until granted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_gnt  out  1  access performed this cycle (combinational)
cpu_rvalid  out  1  read data valid (cycle after a granted read)
cpu_rdata  out  DATA_WIDTH  read data
dma_start  in  1  start pulse
dma_src_base  in  ADDR_WIDTH  DMA source address, sampled on start
dma_busy  out  1  DMA in progress
dma_done  out  1  one-cycle completion pulse
oam_wr_valid  out  1  OAM write strobe
oam_wr_addr  out  8  OAM byte index
oam_wr_data  out  DATA_WIDTH  OAM write data
ram_addr  out  ADDR_WIDTH  to RAM A
ram_wdata  out  DATA_WIDTH  to RAM D_in
ram_ce1  out  1  to RAM CE1
ram_ce2  out  1  to RAM CE2 (write = ce1 & ce2)
ram_oe  out  1  to RAM OE (output forced to all-ones when low)
ram_rdata  in  DATA_WIDTH  from RAM D_out

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all registered outputs are 0, FSM is IDLE, counters are 0.
- Reset mid-DMA aborts the transfer. No dma_done and no further oam_wr_valid are produced.
- One RAM slot per cycle. The slot owner is decided combinationally.
- Slot owner when no DMA read is pending: CPU if cpu_req, otherwise idle.
- Slot owner when a DMA read is pending and cpu_req=1: CPU, unless starve_cnt == STARVE_LIMIT, in which case DMA.
- Slot owner when a DMA read is pending and cpu_req=0: DMA.
- starve_cnt increments on each CPU grant while a DMA read is pending. It clears on a DMA grant or when no DMA is active, and saturates at STARVE_LIMIT.
- CPU grant: cpu_gnt=1, ram_addr=cpu_addr.
  - Write: ram_wdata=cpu_wdata, ram_ce1=ram_ce2=1.
  - Read: ce2=0.
- DMA grant: ram_addr = (base + idx) mod 2^ADDR_WIDTH, a read with ce2=0.
- Idle slot: ram_ce1=ram_ce2=0; ram_addr holds its last value.
- ram_oe is a register, set to 1 in the cycle after any granted read, else 0. Result: ram_rdata is valid exactly when ram_oe=1.
- CPU read return: cpu_rvalid=1 and cpu_rdata=ram_rdata in the cycle after a granted CPU read. Latency is 1 cycle from grant.
- DMA read return: in the cycle after a DMA grant, oam_wr_valid=1, oam_wr_addr=the issued idx, oam_wr_data=ram_rdata.
- FSM states:
  - IDLE: dma_start latches dma_src_base, idx:=0, go to RUN. dma_busy rises the next cycle.
  - RUN: on each DMA grant, idx++. When the grant is issued with idx==DMA_BURST-1, go to DRAIN.
  - DRAIN: the final oam_wr_valid occurs this cycle. dma_done=1 for this cycle only, then go to IDLE.
- dma_busy=1 in RUN and DRAIN.
- dma_start while busy is ignored; no restart, no queueing.
- dma_start with cpu_req in the same cycle: the CPU is granted that cycle, and the DMA issues its first read no earlier than the next cycle.
- Source address wrap: base+idx wraps modulo 2^ADDR_WIDTH (0x1FFF → 0x0000).
- CPU writes to the source region during DMA are not blocked. The DMA reads whatever value is current in its slot.

Test Plan:
- CPU write 0xA5 to 0x0123, then read 0x0123 → cpu_gnt each request cycle; cpu_rvalid one cycle after the read grant with cpu_rdata=0xA5; ram_ce2=1 only on the write cycle.
- RAM preloaded with (addr & 0xFF), dma_start with base 0x0100, no CPU traffic → 160 consecutive oam_wr_valid with oam_wr_addr 0..159 and data 0x00..0x9F; dma_done pulses once, 162 cycles after the start edge; dma_busy low afterwards.
- DMA with cpu_req held high continuously (reads) → pattern of 4 CPU grants then 1 DMA grant, repeating; DMA completes after 800 slots; data order is unchanged.
- Base 0x1FF0 → oam index 16 sources address 0x0000; all 160 bytes are correct.
- dma_start re-pulsed at idx 50 → ignored; exactly one dma_done; idx sequence is unbroken.
- rst_n asserted at idx 80 → all outputs 0 immediately; no dma_done. After release, a new dma_start runs a full 160-byte transfer.
